// File: rtl/mpc_div_36s_15ns_21_seq.sv
// Sequential divider: signed 36-bit a / unsigned 15-bit b -> saturated signed 21-bit q (remainder r under MPC_DIV_REM_EN).
// Fixed 38 enabled-edge latency, ce stalls everything, start is ignored while busy.
module mpc_div_36s_15ns_21_seq #(
  parameter int DIN0_WIDTH = 36,
  parameter int DIN1_WIDTH = 15,
  parameter int DOUT_WIDTH = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         start,
  input  logic signed [DIN0_WIDTH-1:0] a,
  input  logic        [DIN1_WIDTH-1:0] b,
  output logic signed [DOUT_WIDTH-1:0] q,
`ifdef MPC_DIV_REM_EN
  output logic signed [DIN1_WIDTH:0]   r,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         div_zero,
  output logic                         ovf
);

  localparam logic signed [DOUT_WIDTH-1:0] Q_MAX   = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] Q_MIN   = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic        [DIN0_WIDTH-1:0] POS_LIM = 36'd1048575;
  localparam logic        [DIN0_WIDTH-1:0] NEG_LIM = 36'd1048576;
  localparam logic        [5:0]            LAST    = 6'(DIN0_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t                         state, state_nxt;
  logic [5:0]                     cnt;
  logic                           neg;
  logic [DIN0_WIDTH-1:0]          dvd;      // |a| shifts out MSB-first while quotient bits shift in
  logic [DIN1_WIDTH-1:0]          div;
  logic [DIN1_WIDTH:0]            rem;
  logic [DIN0_WIDTH-1:0]          a_mag;
  logic [DIN1_WIDTH+1:0]          rem_sh;
  logic                           rem_ge;
  logic [DIN1_WIDTH:0]            rem_nxt;
  logic signed [DOUT_WIDTH-1:0]   q_fin;
  logic                           ovf_fin;

  always_comb begin
    a_mag   = a[DIN0_WIDTH-1] ? (~$unsigned(a) + 36'd1) : $unsigned(a);
    rem_sh  = {rem, dvd[DIN0_WIDTH-1]};
    rem_ge  = rem_sh >= {2'b00, div};
    rem_nxt = rem_ge ? 16'(rem_sh - {2'b00, div}) : rem_sh[DIN1_WIDTH:0];
  end

  // Sign and saturation of the finished magnitude; b==0 leaves an all-ones quotient, forced explicitly.
  always_comb begin
    q_fin   = neg ? (~dvd[DOUT_WIDTH-1:0] + 21'd1) : dvd[DOUT_WIDTH-1:0];
    ovf_fin = 1'b0;
    if (div == '0) begin
      q_fin   = neg ? Q_MIN : Q_MAX;
      ovf_fin = 1'b1;
    end else if (!neg && dvd > POS_LIM) begin
      q_fin   = Q_MAX;
      ovf_fin = 1'b1;
    end else if (neg && dvd > NEG_LIM) begin
      q_fin   = Q_MIN;
      ovf_fin = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      neg      <= 1'b0;
      dvd      <= '0;
      div      <= '0;
      rem      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
`ifdef MPC_DIV_REM_EN
      r        <= '0;
`endif
    end else if (ce) begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state == FIN);
      case (state)
        IDLE: begin
          if (start) begin
            neg <= a[DIN0_WIDTH-1];
            dvd <= a_mag;
            div <= b;
            rem <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          dvd <= {dvd[DIN0_WIDTH-2:0], rem_ge};
          rem <= rem_nxt;
          cnt <= cnt + 6'd1;
        end
        FIN: begin
          q        <= q_fin;
          ovf      <= ovf_fin;
          div_zero <= (div == '0);
`ifdef MPC_DIV_REM_EN
          r        <= (div == '0) ? '0 : (neg ? (~rem + 16'd1) : rem);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpc_div_36s_15ns_21_seq.sv
// Directed bench for mpc_div_36s_15ns_21_seq: latency, signs, saturation, b==0, ce stalls, reset abort.
module tb_mpc_div_36s_15ns_21_seq;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ce = 1'b0;
  logic               start = 1'b0;
  logic signed [35:0] a = '0;
  logic        [14:0] b = '0;
  logic signed [20:0] q;
`ifdef MPC_DIV_REM_EN
  logic signed [15:0] r;
`endif
  logic               busy, done, div_zero, ovf;

  int checks = 0;
  int failures = 0;
  int edges_seen;
  bit got_done;
  int n_done;

  always #5 clk = ~clk;

  mpc_div_36s_15ns_21_seq dut (
    .clk(clk), .rst(rst), .ce(ce), .start(start), .a(a), .b(b), .q(q),
`ifdef MPC_DIV_REM_EN
    .r(r),
`endif
    .busy(busy), .done(done), .div_zero(div_zero), .ovf(ovf)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issues one start and counts clk edges up to done; optionally drops ce and re-pokes start while busy.
  task automatic do_div(input logic signed [35:0] av, input logic [14:0] bv,
                        input int stall_at, input int stall_len, input bit poke);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; start = 1'b1; ce = 1'b1;
    got_done = 1'b0;
    while (!got_done && n < 200) begin
      @(posedge clk);
      n++;
      #1;
      start = poke && (n == 5 || n == 20 || n == 37);
      if (n == stall_at) ce = 1'b0;
      if (n == stall_at + stall_len) ce = 1'b1;
      got_done = done;
    end
    edges_seen = n;
  endtask

  task automatic run_vec(input string tag, input logic signed [35:0] av, input logic [14:0] bv,
                         input logic signed [20:0] eq, input logic signed [15:0] er,
                         input bit eovf, input bit edz);
    do_div(av, bv, 0, 0, 1'b0);
    chk({tag, ".lat"}, edges_seen, 38);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".ovf"}, ovf, eovf);
    chk({tag, ".dz"}, div_zero, edz);
`ifdef MPC_DIV_REM_EN
    chk({tag, ".r"}, r, er);
`endif
  endtask

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("rst.q", q, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.dz", div_zero, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Back-to-back: each call raises start in the cycle right after the previous done.
    run_vec("v1",  36'sd1000, 15'd10, 21'sd100, 16'sd0, 1'b0, 1'b0);
    run_vec("v2",  -36'sd1000, 15'd7, -21'sd142, -16'sd6, 1'b0, 1'b0);
    run_vec("v3",  36'sh800000000, 15'd32767, -21'sd1048576, -16'sd32, 1'b1, 1'b0);
    run_vec("v4",  36'sd1073741824, 15'd1, 21'sd1048575, 16'sd0, 1'b1, 1'b0);
    run_vec("v5",  36'sd5, 15'd0, 21'sd1048575, 16'sd0, 1'b1, 1'b1);
    run_vec("v6",  -36'sd5, 15'd0, -21'sd1048576, 16'sd0, 1'b1, 1'b1);
    run_vec("v7",  36'sd1048575, 15'd1, 21'sd1048575, 16'sd0, 1'b0, 1'b0);
    run_vec("v8",  -36'sd1048576, 15'd1, -21'sd1048576, 16'sd0, 1'b0, 1'b0);
    run_vec("v9",  -36'sd1048577, 15'd1, -21'sd1048576, 16'sd0, 1'b1, 1'b0);
    run_vec("v10", -36'sd7, 15'd2, -21'sd3, -16'sd1, 1'b0, 1'b0);
    run_vec("v11", 36'sd0, 15'd5, 21'sd0, 16'sd0, 1'b0, 1'b0);
    run_vec("v12", 36'sd34359738367, 15'd32767, 21'sd1048575, 16'sd31, 1'b1, 1'b0);
    run_vec("v13", 36'sd123456, 15'd1000, 21'sd123, 16'sd456, 1'b0, 1'b0);

    // done must stay high across disabled edges and drop on the next enabled one.
    ce = 1'b0;
    @(posedge clk); #1;
    chk("hold.done1", done, 1);
    @(posedge clk); #1;
    chk("hold.done2", done, 1);
    ce = 1'b1;
    @(posedge clk); #1;
    chk("hold.done_clr", done, 0);
    chk("hold.q", q, 123);
    chk("hold.busy", busy, 0);

    // Stall 5 cycles mid-CALC with start pokes while busy.
    do_div(36'sd1000, 15'd10, 10, 5, 1'b1);
    chk("stall.lat", edges_seen, 43);
    chk("stall.q", q, 100);
    n_done = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("stall.single_done", n_done, 0);
    chk("stall.busy", busy, 0);

    // Abort a division with reset at enabled edge 20 after a result with flags set.
    run_vec("pre", -36'sd5, 15'd0, -21'sd1048576, 16'sd0, 1'b1, 1'b1);
    @(negedge clk);
    a = 36'sd1000; b = 15'd10; start = 1'b1; ce = 1'b1;
    repeat (20) begin
      @(posedge clk); #1 start = 1'b0;
    end
    chk("abort.busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort.q", q, 0);
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.ovf", ovf, 0);
    chk("abort.dz", div_zero, 0);
    @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    chk("abort.no_done", n_done, 0);
    run_vec("post", 36'sd1000, 15'd10, 21'sd100, 16'sd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
